seq_div_nbits: RTL



---
 rtl/div_pkg.sv | 14 +
 rtl/div_trial_sub.sv | 14 +
 rtl/seq_div_nbits.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helper for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational trial subtractor; neg_o is the borrow/sign bit
module div_trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         neg_o
);

  assign diff_o = a_i - b_i;
  assign neg_o  = diff_o[W-1];

endmodule

// File: rtl/seq_div_nbits.sv
// rtl/seq_div_nbits.sv - iterative restoring divider, one quotient bit per clock
// SIGNED_DIV_EN selects two's-complement operands (magnitude divide plus sign fix-up).
module seq_div_nbits
  import div_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int CW = cnt_w(n);

  div_state_t    state_q, state_d;
  logic [n:0]    a_q, a_d;
  logic [n-1:0]  q_q, q_d;
  logic [n-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  quot_q, quot_d;
  logic [n-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;

  logic [n:0]    a_shift, t_diff, a_step;
  logic [n-1:0]  q_shift, q_step;
  logic          t_neg;
  logic [n-1:0]  dvd_mag, dvs_mag, quot_fix, rem_fix;
  logic          ovf_fix;

  assign a_shift = {a_q[n-1:0], q_q[n-1]};
  assign q_shift = {q_q[n-2:0], 1'b0};

  div_trial_sub #(.W(n + 1)) u_trial (
    .a_i    (a_shift),
    .b_i    ({1'b0, m_q}),
    .diff_o (t_diff),
    .neg_o  (t_neg)
  );

  assign a_step = t_neg ? a_shift : t_diff;
  assign q_step = {q_shift[n-1:1], ~t_neg};

  // Magnitudes feed the unsigned core; the most-negative value maps to 2^(n-1) unsigned.
  assign dvd_mag  = (SIGNED_EN && dividend[n-1]) ? -dividend : dividend;
  assign dvs_mag  = (SIGNED_EN && divisor[n-1])  ? -divisor  : divisor;
  assign quot_fix = qneg_q ? -q_step : q_step;
  assign rem_fix  = rneg_q ? -a_step[n-1:0] : a_step[n-1:0];
  // A positive signed quotient can only reach the msb for most-negative / -1.
  assign ovf_fix  = SIGNED_EN && !qneg_q && q_step[n-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = '0;
            q_d     = dvd_mag;
            m_d     = dvs_mag;
            cnt_d   = '0;
            qneg_d  = SIGNED_EN && (dividend[n-1] ^ divisor[n-1]);
            rneg_d  = SIGNED_EN && dividend[n-1];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d   = a_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(n - 1)) begin
          quot_d  = quot_fix;
          rem_d   = rem_fix;
          ovf_d   = ovf_fix;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
